alu_wb_rfa_arbiter: RTL
=======================

// Module: alu_wb_rfa_arbiter
// PURPOSE
// Register-file write arbiter fed by NUM_QUEUES ALU writeback queues (one per SIMD/SALU).
// Picks at most one non-empty queue per cycle and pulses that queue's entry_serviced (head pop).
// Muxes the winning head entry into a single registered VGPR/SGPR/VCC write-port command.
// Also drives the instruction-done report. Starved near-full queues are promoted ahead of others.
// PARAMETERS
// NUM_QUEUES  4  number of writeback queues arbitrated (2..8)
// QSEL_BITS   2  width of queue index, = clog2(NUM_QUEUES)
// PORTS
// clk                         in   1            clock; all state on rising edge
// rst                         in   1            asynchronous reset, active-low (0 = reset)
// in_port_stall               in   1            RF write port owned elsewhere this cycle; no grant
// in_queue_empty              in   NQ           per-queue empty flag
// in_queue_ready              in   NQ           per-queue ready; 0 = <=1 free slot (urgent)
// in_vgpr_dest_data           in   NQ*2048      flattened head entries; queue i at [i*W +: W]
// in_sgpr_dest_data           in   NQ*64        "
// in_exec_wr_vcc_value        in   NQ*64        "
// in_vgpr_wr_mask             in   NQ*64        "
// in_wfid                     in   NQ*6         "
// in_instr_pc                 in   NQ*32        "
// in_vgpr_dest_addr           in   NQ*10        "
// in_sgpr_dest_addr           in   NQ*9         "
// in_ctrl                     in   NQ*4         {instr_done, vgpr_wr_en, sgpr_wr_en, vcc_wr_en}
// out_rfa_queue_entry_serviced out  NQ          one-hot pop, combinational, same cycle as grant
// out_vgpr_dest_data/_wr_mask/_addr/_wr_en      out  2048/64/10/1  registered VGPR write
// out_sgpr_dest_data/_addr/_wr_en               out  64/9/1        registered SGPR write
// out_vcc_value, out_vcc_wr_en                  out  64/1          registered VCC write
// out_instr_done, out_wfid, out_instr_pc        out  1/6/32        registered retire report
// out_grant_qid               out  QSEL_BITS    registered index of the winning queue
// BEHAVIOUR
// - Reset (rst=0, async): rr_ptr=0; all registered outputs 0; serviced=0 while rst=0.
// - eligible[i] = ~in_queue_empty[i]; urgent[i] = eligible[i] & ~in_queue_ready[i].
// - in_port_stall=1 or no eligible -> serviced=0; next cycle all *_wr_en/instr_done=0.
// - Else if any urgent: round-robin among urgent; otherwise round-robin among eligible.
// - Round-robin: search from rr_ptr upward, wrapping NUM_QUEUES-1 -> 0.
// - On a grant to g: rr_ptr <= (g+1) mod NUM_QUEUES. No grant: rr_ptr holds.
// - Grant g: serviced[g]=1 same cycle; head fields of g captured at the clock edge.
// - Outputs valid the next cycle (latency 1). Exactly one pop per grant; never pop an empty queue.
// - Write enables pass through gated by the grant: an entry with all wr_en=0 still pops.
// - That entry reports instr_done only; out_*_data of non-granted cycles is don't-care.
// - Head updates on the pop edge, so the next cycle's empty/head values are current.
// - The same queue may win back-to-back; no bubble is required.
// - Stall rising while a queue is urgent: nothing pops. The queue's own writable check
//   prevents overflow; no loss here.
// - Async reset mid-stream: the in-flight registered command is dropped (wr_en forced 0).
// - Queues' rst must be asserted together with this block's rst.
// STRUCTURE
// - Shared package/header: VGPR_DATA_W=2048, SGPR_DATA_W=64, MASK_W=64, WFID_W=6, PC_W=32,
//   VADDR_W=10, SADDR_W=9, CTRL_W=4.
// - Also in the package: the CTRL bit positions (DONE=3, VGPR=2, SGPR=1, VCC=0).
// - Sub-module rr_prio_arbiter #(N): inputs req, hi_req, ptr.
//   Outputs one-hot gnt, gnt_idx, valid. Purely combinational.
// - Top: arbiter, AND-OR one-hot mux of head fields, output regs, rr_ptr reg (async active-low).
// TESTING
// - Reset: rst=0 with all queues non-empty -> serviced=0, all wr_en=0; after release first grant is q0.
// - Fairness: all 4 non-empty and ready for 8 cycles -> grants 0,1,2,3,0,1,2,3.
//   Each output appears 1 cycle after its pop.
// - Urgency: q0..q3 eligible, q2 ready=0, rr_ptr=0 -> q2 granted first. Then q3,q0,q1 once q2 ready=1.
// - Stall: in_port_stall=1 for 3 cycles with q1 non-empty -> no pop, no wr_en, rr_ptr unchanged.
//   Then q1 is granted.
// - Wrap: only q3 non-empty, rr_ptr=3 -> grant q3, rr_ptr=0. q3 again next cycle -> granted (wrap search).
// - Field routing: q1 head vgpr_addr=10'h155, sgpr_wr_en=1, sgpr_addr=9'h0A0 -> next cycle
//   out_grant_qid=1, out_vgpr_dest_addr=10'h155, out_sgpr_dest_addr=9'h0A0, out_sgpr_dest_wr_en=1.

Source files
------------

// File: rtl/alu_wb_rfa_arbiter_pkg.sv
// Shared field widths and control-bit layout for the ALU writeback
// register-file arbiter and its round-robin priority arbiter.
package alu_wb_rfa_arbiter_pkg;

    localparam int VGPR_DATA_W = 2048;
    localparam int SGPR_DATA_W = 64;
    localparam int MASK_W      = 64;
    localparam int WFID_W      = 6;
    localparam int PC_W        = 32;
    localparam int VADDR_W     = 10;
    localparam int SADDR_W     = 9;
    localparam int CTRL_W      = 4;

    // Bit positions inside a queue entry's ctrl field
    localparam int CTRL_DONE = 3;
    localparam int CTRL_VGPR = 2;
    localparam int CTRL_SGPR = 1;
    localparam int CTRL_VCC  = 0;

    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_NORMAL = 2'd1,
        SRC_URGENT = 2'd2
    } grant_src_e;

endpackage

// File: rtl/alu_wb_rfa_arbiter_rr_prio_arbiter.sv
// Combinational round-robin arbiter with a high-priority request class:
// if any hi_req is set only those compete, otherwise all of req compete.
module rr_prio_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  hi_req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          valid
);

    logic [N-1:0] w_pool;
    logic [N-1:0] w_upper;
    logic [N-1:0] w_src;

    // Requests at or above ptr take precedence; if none, the search wraps to
    // the lowest requester, which gives the rotating search order.
    always_comb begin
        w_pool  = (|hi_req) ? hi_req : req;
        w_upper = '0;
        for (int j = 0; j < N; j++) begin
            w_upper[j] = w_pool[j] && (j >= int'(ptr));
        end
        w_src   = (|w_upper) ? w_upper : w_pool;
        gnt     = '0;
        gnt_idx = '0;
        valid   = |w_src;
        for (int j = N - 1; j >= 0; j--) begin
            if (w_src[j]) begin
                gnt     = '0;
                gnt[j]  = 1'b1;
                gnt_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/alu_wb_rfa_arbiter.sv
// Register-file write arbiter: pops at most one ALU writeback queue per cycle
// and turns its head entry into a registered VGPR/SGPR/VCC write plus retire report.
module alu_wb_rfa_arbiter
    import alu_wb_rfa_arbiter_pkg::*;
#(
    parameter int NUM_QUEUES = 4,
    parameter int QSEL_BITS  = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_port_stall,
    input  logic [NUM_QUEUES-1:0]             in_queue_empty,
    input  logic [NUM_QUEUES-1:0]             in_queue_ready,
    input  logic [NUM_QUEUES*VGPR_DATA_W-1:0] in_vgpr_dest_data,
    input  logic [NUM_QUEUES*SGPR_DATA_W-1:0] in_sgpr_dest_data,
    input  logic [NUM_QUEUES*MASK_W-1:0]      in_exec_wr_vcc_value,
    input  logic [NUM_QUEUES*MASK_W-1:0]      in_vgpr_wr_mask,
    input  logic [NUM_QUEUES*WFID_W-1:0]      in_wfid,
    input  logic [NUM_QUEUES*PC_W-1:0]        in_instr_pc,
    input  logic [NUM_QUEUES*VADDR_W-1:0]     in_vgpr_dest_addr,
    input  logic [NUM_QUEUES*SADDR_W-1:0]     in_sgpr_dest_addr,
    input  logic [NUM_QUEUES*CTRL_W-1:0]      in_ctrl,
    output logic [NUM_QUEUES-1:0]             out_rfa_queue_entry_serviced,
    output logic [VGPR_DATA_W-1:0]            out_vgpr_dest_data,
    output logic [MASK_W-1:0]                 out_vgpr_wr_mask,
    output logic [VADDR_W-1:0]                out_vgpr_dest_addr,
    output logic                              out_vgpr_dest_wr_en,
    output logic [SGPR_DATA_W-1:0]            out_sgpr_dest_data,
    output logic [SADDR_W-1:0]                out_sgpr_dest_addr,
    output logic                              out_sgpr_dest_wr_en,
    output logic [MASK_W-1:0]                 out_vcc_value,
    output logic                              out_vcc_wr_en,
    output logic                              out_instr_done,
    output logic [WFID_W-1:0]                 out_wfid,
    output logic [PC_W-1:0]                   out_instr_pc,
    output logic [QSEL_BITS-1:0]              out_grant_qid
);

    logic [QSEL_BITS-1:0]   r_rr_ptr;
    logic [NUM_QUEUES-1:0]  w_eligible;
    logic [NUM_QUEUES-1:0]  w_urgent;
    logic [NUM_QUEUES-1:0]  w_arb_gnt;
    logic [QSEL_BITS-1:0]   w_arb_idx;
    logic                   w_arb_valid;
    logic                   w_grant;

    logic [VGPR_DATA_W-1:0] w_vdata;
    logic [MASK_W-1:0]      w_mask;
    logic [SGPR_DATA_W-1:0] w_sdata;
    logic [MASK_W-1:0]      w_vcc;
    logic [WFID_W-1:0]      w_wfid;
    logic [PC_W-1:0]        w_pc;
    logic [VADDR_W-1:0]     w_vaddr;
    logic [SADDR_W-1:0]     w_saddr;
    logic [CTRL_W-1:0]      w_ctrl;

    logic [VGPR_DATA_W-1:0] r_vdata;
    logic [MASK_W-1:0]      r_mask;
    logic [VADDR_W-1:0]     r_vaddr;
    logic                   r_vgpr_wr_en;
    logic [SGPR_DATA_W-1:0] r_sdata;
    logic [SADDR_W-1:0]     r_saddr;
    logic                   r_sgpr_wr_en;
    logic [MASK_W-1:0]      r_vcc;
    logic                   r_vcc_wr_en;
    logic                   r_instr_done;
    logic [WFID_W-1:0]      r_wfid;
    logic [PC_W-1:0]        r_pc;
    logic [QSEL_BITS-1:0]   r_grant_qid;

    assign w_eligible = ~in_queue_empty;
    assign w_urgent   = w_eligible & ~in_queue_ready;

    rr_prio_arbiter #(
        .N  (NUM_QUEUES),
        .IW (QSEL_BITS)
    ) u_arb (
        .req     (w_eligible),
        .hi_req  (w_urgent),
        .ptr     (r_rr_ptr),
        .gnt     (w_arb_gnt),
        .gnt_idx (w_arb_idx),
        .valid   (w_arb_valid)
    );

    // Pops are suppressed while reset is held so no queue loses an entry.
    assign w_grant = w_arb_valid & ~in_port_stall & rst;
    assign out_rfa_queue_entry_serviced = w_arb_gnt & {NUM_QUEUES{w_grant}};

    // AND-OR mux keyed directly by the one-hot grant vector.
    always_comb begin
        w_vdata = '0;
        w_mask  = '0;
        w_sdata = '0;
        w_vcc   = '0;
        w_wfid  = '0;
        w_pc    = '0;
        w_vaddr = '0;
        w_saddr = '0;
        w_ctrl  = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            w_vdata = w_vdata | ({VGPR_DATA_W{w_arb_gnt[q]}} & in_vgpr_dest_data[q*VGPR_DATA_W +: VGPR_DATA_W]);
            w_mask  = w_mask  | ({MASK_W{w_arb_gnt[q]}}      & in_vgpr_wr_mask[q*MASK_W +: MASK_W]);
            w_sdata = w_sdata | ({SGPR_DATA_W{w_arb_gnt[q]}} & in_sgpr_dest_data[q*SGPR_DATA_W +: SGPR_DATA_W]);
            w_vcc   = w_vcc   | ({MASK_W{w_arb_gnt[q]}}      & in_exec_wr_vcc_value[q*MASK_W +: MASK_W]);
            w_wfid  = w_wfid  | ({WFID_W{w_arb_gnt[q]}}      & in_wfid[q*WFID_W +: WFID_W]);
            w_pc    = w_pc    | ({PC_W{w_arb_gnt[q]}}        & in_instr_pc[q*PC_W +: PC_W]);
            w_vaddr = w_vaddr | ({VADDR_W{w_arb_gnt[q]}}     & in_vgpr_dest_addr[q*VADDR_W +: VADDR_W]);
            w_saddr = w_saddr | ({SADDR_W{w_arb_gnt[q]}}     & in_sgpr_dest_addr[q*SADDR_W +: SADDR_W]);
            w_ctrl  = w_ctrl  | ({CTRL_W{w_arb_gnt[q]}}      & in_ctrl[q*CTRL_W +: CTRL_W]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr <= '0;
        end else if (w_grant) begin
            r_rr_ptr <= (w_arb_idx == QSEL_BITS'(NUM_QUEUES - 1)) ? '0 : w_arb_idx + 1'b1;
        end
    end

    // Payload fields only load on a grant; idle cycles just drop the enables.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vdata      <= '0;
            r_mask       <= '0;
            r_vaddr      <= '0;
            r_vgpr_wr_en <= 1'b0;
            r_sdata      <= '0;
            r_saddr      <= '0;
            r_sgpr_wr_en <= 1'b0;
            r_vcc        <= '0;
            r_vcc_wr_en  <= 1'b0;
            r_instr_done <= 1'b0;
            r_wfid       <= '0;
            r_pc         <= '0;
            r_grant_qid  <= '0;
        end else if (w_grant) begin
            r_vdata      <= w_vdata;
            r_mask       <= w_mask;
            r_vaddr      <= w_vaddr;
            r_vgpr_wr_en <= w_ctrl[CTRL_VGPR];
            r_sdata      <= w_sdata;
            r_saddr      <= w_saddr;
            r_sgpr_wr_en <= w_ctrl[CTRL_SGPR];
            r_vcc        <= w_vcc;
            r_vcc_wr_en  <= w_ctrl[CTRL_VCC];
            r_instr_done <= w_ctrl[CTRL_DONE];
            r_wfid       <= w_wfid;
            r_pc         <= w_pc;
            r_grant_qid  <= w_arb_idx;
        end else begin
            r_vgpr_wr_en <= 1'b0;
            r_sgpr_wr_en <= 1'b0;
            r_vcc_wr_en  <= 1'b0;
            r_instr_done <= 1'b0;
        end
    end

    assign out_vgpr_dest_data  = r_vdata;
    assign out_vgpr_wr_mask    = r_mask;
    assign out_vgpr_dest_addr  = r_vaddr;
    assign out_vgpr_dest_wr_en = r_vgpr_wr_en;
    assign out_sgpr_dest_data  = r_sdata;
    assign out_sgpr_dest_addr  = r_saddr;
    assign out_sgpr_dest_wr_en = r_sgpr_wr_en;
    assign out_vcc_value       = r_vcc;
    assign out_vcc_wr_en       = r_vcc_wr_en;
    assign out_instr_done      = r_instr_done;
    assign out_wfid            = r_wfid;
    assign out_instr_pc        = r_pc;
    assign out_grant_qid       = r_grant_qid;

endmodule
